// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain
//   Consumer side of a synchronous FIFO. Issues reads with a credit rule so
//   that the FIFO's one-cycle registered read latency is absorbed by a
//   3-entry output buffer, and presents the words as a valid/ready stream.
//   Every FRAME_LEN-th transferred word is flagged with out_last, and
//   completed frames are counted in frame_cnt (wrapping).
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  FIFO read enable (combinational, independent of out_ready)
//   out_data    head-of-buffer word
//   out_valid   out_data is valid
//   out_ready   sink accepts; transfer = out_valid & out_ready
//   out_last    head word is the last word of its frame
//   frame_cnt   completed frames, modulo 2^CNT_W
module fifo_stream_drain #(
  parameter int bits      = 8,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [bits-1:0]  fifo_data,
  output logic             fifo_rd_en,
  output logic [bits-1:0]  out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } occ_t;

  occ_t             occ_r;
  logic             inflight_r;
  logic [bits-1:0]  buf_r [3];
  logic [IDX_W-1:0] word_idx_r;

  logic             pop_s;
  logic             up_s;
  logic             down_s;
  logic [2:0]       credit_s;
  logic [1:0]       slot_s;
  logic             valid_next_s;
  logic [IDX_W-1:0] idx_next_s;

  assign pop_s    = out_valid & out_ready;
  assign up_s     = inflight_r & ~pop_s;
  assign down_s   = pop_s & ~inflight_r;
  // Words already buffered plus the one still in flight must leave room
  // for the read being issued now, so the buffer can never overflow.
  assign credit_s   = {1'b0, occ_r} + {2'b00, inflight_r};
  assign fifo_rd_en = ~rst & ~fifo_empty & (credit_s <= 3'd2);
  assign out_data   = buf_r[0];

  // Tail slot for a captured word; a simultaneous pop shifts the buffer down first.
  always_comb begin
    slot_s = 2'd0;
    if (pop_s) begin
      slot_s = occ_r - 2'd1;
    end else begin
      slot_s = occ_r;
    end
  end

  // Next-cycle valid and frame index, used to register out_valid/out_last.
  always_comb begin
    valid_next_s = inflight_r | (occ_r == TWO) | (occ_r == FULL) |
                   ((occ_r == ONE) & ~pop_s);
    idx_next_s = word_idx_r;
    if (pop_s) begin
      if (word_idx_r == LAST_IDX) begin
        idx_next_s = '0;
      end else begin
        idx_next_s = word_idx_r + IDX_W'(1);
      end
    end else begin
      idx_next_s = word_idx_r;
    end
  end

  // Occupancy FSM, read pipeline tracking, framing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r      <= EMPTY;
      inflight_r <= 1'b0;
      word_idx_r <= '0;
      frame_cnt  <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      inflight_r <= fifo_rd_en;
      case (occ_r)
        EMPTY: begin
          if (up_s) occ_r <= ONE;
          else      occ_r <= EMPTY;
        end
        ONE: begin
          if (up_s)        occ_r <= TWO;
          else if (down_s) occ_r <= EMPTY;
          else             occ_r <= ONE;
        end
        TWO: begin
          if (up_s)        occ_r <= FULL;
          else if (down_s) occ_r <= ONE;
          else             occ_r <= TWO;
        end
        FULL: begin
          if (down_s) occ_r <= TWO;
          else        occ_r <= FULL;
        end
        default: occ_r <= EMPTY;
      endcase
      out_valid  <= valid_next_s;
      out_last   <= valid_next_s & (idx_next_s == LAST_IDX);
      word_idx_r <= idx_next_s;
      if (pop_s && (word_idx_r == LAST_IDX)) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end else begin
        frame_cnt <= frame_cnt;
      end
    end
  end

  // Output buffer: head at entry 0, pop shifts down, capture lands at the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_r[0] <= '0;
      buf_r[1] <= '0;
      buf_r[2] <= '0;
    end else begin
      if (pop_s) begin
        buf_r[0] <= buf_r[1];
        buf_r[1] <= buf_r[2];
      end else begin
        buf_r[0] <= buf_r[0];
      end
      // The later non-blocking write wins over the shift for the tail slot.
      if (inflight_r) begin
        case (slot_s)
          2'd0:    buf_r[0] <= fifo_data;
          2'd1:    buf_r[1] <= fifo_data;
          2'd2:    buf_r[2] <= fifo_data;
          default: buf_r[2] <= buf_r[2];
        endcase
      end else begin
        buf_r[2] <= buf_r[2];
      end
    end
  end

endmodule
